// File: rtl/ssd_scan_mux_if.sv
// Display-side bundle for ssd_scan_mux: digit values and DP enables in,
// active-low anode/cathode/DP drive out.
interface ssd_scan_mux_if;
  logic [3:0] i_Digit_1_val;
  logic [3:0] i_Digit_2_val;
  logic [3:0] i_Digit_3_val;
  logic [3:0] i_Digit_4_val;
  logic [3:0] i_DP;
  logic [3:0] o_Anode;
  logic [6:0] o_Cathode;
  logic       o_DP;

  modport master (
    output i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
    input  o_Anode, o_Cathode, o_DP
  );

  modport slave (
    input  i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
    output o_Anode, o_Cathode, o_DP
  );
endinterface

// File: rtl/ssd_scan_mux.sv
// Four-digit common-anode seven-segment scanner with per-frame snapshot,
// hex decode, leading-zero blanking and an all-off guard at each slot start.
module ssd_scan_mux #(
  parameter int c_REFRESH_DIV   = 100000,
  parameter int c_GUARD         = 2,
  parameter int c_BLANK_LEADING = 1
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  ssd_scan_mux_if.slave bus
);

  localparam int CW = $clog2(c_REFRESH_DIV);

  logic [CW-1:0] r_Slot_cnt;
  logic [1:0]    r_Scan_idx;
  logic          r_Init;
  // Shadow index matches scan index: [0] = digit 4 (rightmost), [3] = digit 1.
  logic [3:0]    r_Shadow [4];
  logic [3:0]    r_Shadow_dp;

  logic          slot_last;
  logic          frame_load;
  logic [3:0]    sel_val;
  logic          sel_dp;
  logic [3:0]    lead_zero;
  logic          blanked;
  logic [3:0]    next_anode;
  logic [6:0]    next_cathode;
  logic          next_dp;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      4'hF: decode = 7'h0E;
    endcase
  endfunction

  assign slot_last  = (r_Slot_cnt == CW'(c_REFRESH_DIV - 1));
  assign frame_load = r_Init || (slot_last && (r_Scan_idx == 2'd3));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_Slot_cnt <= '0;
      r_Scan_idx <= 2'd0;
    end else if (slot_last) begin
      r_Slot_cnt <= '0;
      r_Scan_idx <= r_Scan_idx + 2'd1;
    end else begin
      r_Slot_cnt <= r_Slot_cnt + 1'b1;
    end
  end

  // Snapshot on the first edge out of reset and at every frame boundary.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_Init      <= 1'b1;
      r_Shadow_dp <= 4'd0;
      for (int i = 0; i < 4; i++) r_Shadow[i] <= 4'd0;
    end else begin
      r_Init <= 1'b0;
      if (frame_load) begin
        r_Shadow[3] <= bus.i_Digit_1_val;
        r_Shadow[2] <= bus.i_Digit_2_val;
        r_Shadow[1] <= bus.i_Digit_3_val;
        r_Shadow[0] <= bus.i_Digit_4_val;
        r_Shadow_dp <= bus.i_DP;
      end
    end
  end

  always_comb begin
    next_anode   = 4'b1111;
    next_cathode = 7'h7F;
    next_dp      = 1'b1;
    sel_val      = r_Shadow[r_Scan_idx];
    sel_dp       = r_Shadow_dp[r_Scan_idx];
    lead_zero[3] = (r_Shadow[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (r_Shadow[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (r_Shadow[1] == 4'd0);
    lead_zero[0] = 1'b0;
    blanked      = (c_BLANK_LEADING != 0) && lead_zero[r_Scan_idx];
    // A blanked digit still lights its anode when it carries a decimal point.
    if (r_Slot_cnt >= CW'(c_GUARD)) begin
      if (!blanked || sel_dp) next_anode[r_Scan_idx] = 1'b0;
      if (!blanked) next_cathode = decode(sel_val);
      next_dp = ~sel_dp;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      bus.o_Anode   <= 4'b1111;
      bus.o_Cathode <= 7'h7F;
      bus.o_DP      <= 1'b1;
    end else begin
      bus.o_Anode   <= next_anode;
      bus.o_Cathode <= next_cathode;
      bus.o_DP      <= next_dp;
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: two instances (blanking on/off) compared every
// cycle against a frame/slot reference model driven by edge count.
module tb_ssd_scan_mux;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] dig [4];
  logic [3:0] dp;

  int checks = 0;
  int errors = 0;
  int k      = 0;
  logic [11:0] exp_a = 12'hFFF;
  logic [11:0] exp_b = 12'hFFF;
  logic [3:0]  sh_d [4];
  logic [3:0]  sh_dp;
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_mux_if bus_a ();
  ssd_scan_mux_if bus_b ();

  assign bus_a.i_Digit_1_val = dig[0];
  assign bus_a.i_Digit_2_val = dig[1];
  assign bus_a.i_Digit_3_val = dig[2];
  assign bus_a.i_Digit_4_val = dig[3];
  assign bus_a.i_DP          = dp;
  assign bus_b.i_Digit_1_val = dig[0];
  assign bus_b.i_Digit_2_val = dig[1];
  assign bus_b.i_Digit_3_val = dig[2];
  assign bus_b.i_Digit_4_val = dig[3];
  assign bus_b.i_DP          = dp;

  wire [11:0] act_a = {bus_a.o_Anode, bus_a.o_Cathode, bus_a.o_DP};
  wire [11:0] act_b = {bus_b.o_Anode, bus_b.o_Cathode, bus_b.o_DP};

  ssd_scan_mux #(.c_REFRESH_DIV(DIV), .c_GUARD(GUARD), .c_BLANK_LEADING(1)) dut_a (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(bus_a));
  ssd_scan_mux #(.c_REFRESH_DIV(DIV), .c_GUARD(GUARD), .c_BLANK_LEADING(0)) dut_b (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(bus_b));

  always #5 clk = ~clk;

  // Display for one slot position given the frame's digits (d[0] = leftmost).
  function automatic logic [11:0] model_out(int slot, int idx, logic [3:0] d [4],
                                            logic [3:0] dpv, bit blank_en);
    int pos, lz;
    logic blanked, dpb;
    logic [3:0] an;
    logic [6:0] ca;
    if (slot < GUARD) return 12'hFFF;
    pos = 3 - idx;
    lz  = 0;
    while (lz < 3 && d[lz] == 4'd0) lz++;
    blanked = blank_en && (pos < lz);
    dpb = dpv[idx];
    an  = 4'hF;
    if (!blanked || dpb) an[idx] = 1'b0;
    ca = blanked ? 7'h7F : glyph[d[pos]];
    return {an, ca, ~dpb};
  endfunction

  // k = edges since reset release before this edge; frame loads at k=0 and at each frame end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     = 0;
      exp_a = 12'hFFF;
      exp_b = 12'hFFF;
      for (int i = 0; i < 4; i++) sh_d[i] = 4'd0;
      sh_dp = 4'd0;
    end else begin
      exp_a = model_out(k % DIV, (k / DIV) % 4, sh_d, sh_dp, 1'b1);
      exp_b = model_out(k % DIV, (k / DIV) % 4, sh_d, sh_dp, 1'b0);
      if (k == 0 || (k % FRAME) == FRAME - 1) begin
        sh_d  = dig;
        sh_dp = dp;
      end
      k++;
    end
  end

  task automatic set_digits(input logic [3:0] d1, d2, d3, d4, input logic [3:0] p);
    dig[0] = d1; dig[1] = d2; dig[2] = d3; dig[3] = d4; dp = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
      checks += 2;
      if (act_a !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_hold_a got %h want fff", act_a); end
      if (act_b !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_hold_b got %h want fff", act_b); end
    end
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    int lit [4] = '{0, 0, 0, 0};
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks += 3;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL basic_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL basic_b k=%0d got %h want %h", k, act_b, exp_b); end
      if ($countones(~bus_a.o_Anode) > 1) begin errors++; $display("[TB] FAIL one_hot k=%0d got %b want <=1 low", k, bus_a.o_Anode); end
      for (int i = 0; i < 4; i++) if (bus_a.o_Anode == ~(4'b0001 << i)) lit[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lit[i] != 2 * (DIV - GUARD)) begin
        errors++; $display("[TB] FAIL anode_low_time idx=%0d got %0d want %0d", i, lit[i], 2 * (DIV - GUARD));
      end
    end
  endtask

  task automatic test_blanking(input logic [3:0] d1, d2, d3, d4, input int want_lit_a);
    int lit_a = 0, lit_b = 0;
    set_digits(d1, d2, d3, d4, 4'b0000);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks += 2;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL blank_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL blank_b k=%0d got %h want %h", k, act_b, exp_b); end
      if (c >= FRAME && bus_a.o_Anode != 4'hF) lit_a++;
      if (c >= FRAME && bus_b.o_Anode != 4'hF) lit_b++;
    end
    checks += 2;
    if (lit_a != want_lit_a) begin errors++; $display("[TB] FAIL blank_lit_a got %0d want %0d", lit_a, want_lit_a); end
    if (lit_b != 4 * (DIV - GUARD)) begin errors++; $display("[TB] FAIL blank_lit_b got %0d want %0d", lit_b, 4 * (DIV - GUARD)); end
  endtask

  task automatic test_hex_dp();
    int dp_on = 0;
    set_digits(4'hA, 4'hB, 4'hC, 4'hF, 4'b0100);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks += 2;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL hex_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL hex_b k=%0d got %h want %h", k, act_b, exp_b); end
      if (c >= FRAME && bus_a.o_DP == 1'b0) begin
        dp_on++;
        checks++;
        if (bus_a.o_Anode !== 4'b1011) begin errors++; $display("[TB] FAIL dp_slot got %b want 1011", bus_a.o_Anode); end
      end
    end
    checks++;
    if (dp_on != DIV - GUARD) begin errors++; $display("[TB] FAIL dp_cycles got %0d want %0d", dp_on, DIV - GUARD); end
  endtask

  task automatic test_frame_coherence();
    int nines = 0;
    int guard_cnt = 0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    repeat (FRAME) @(negedge clk);
    while ((k % FRAME) != DIV + 2 && guard_cnt < 2 * FRAME) begin @(negedge clk); guard_cnt++; end
    checks++;
    if ((k % FRAME) != DIV + 2) begin errors++; $display("[TB] FAIL coherence_align got %0d want %0d", k % FRAME, DIV + 2); end
    set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'b0000);
    for (int c = 0; c < FRAME - (DIV + 2) + FRAME; c++) begin
      @(negedge clk);
      checks += 2;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL coherence_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL coherence_b k=%0d got %h want %h", k, act_b, exp_b); end
      if (bus_a.o_Cathode == 7'h10) nines++;
    end
    checks++;
    if (nines != 4 * (DIV - GUARD)) begin errors++; $display("[TB] FAIL coherence_nines got %0d want %0d", nines, 4 * (DIV - GUARD)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 8 * FRAME; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        // Bias toward zeros so blanking paths get exercised.
        for (int i = 0; i < 4; i++) dig[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        dp = 4'($urandom);
      end
      @(negedge clk);
      checks += 2;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL random_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL random_b k=%0d got %h want %h", k, act_b, exp_b); end
    end
  endtask

  task automatic test_reset_mid_slot();
    int guard_cnt = 0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111);
    while ((k % FRAME) != 2 * DIV + 5 && guard_cnt < 2 * FRAME) begin @(negedge clk); guard_cnt++; end
    checks++;
    if ((k % FRAME) != 2 * DIV + 5) begin errors++; $display("[TB] FAIL midslot_align got %0d want %0d", k % FRAME, 2 * DIV + 5); end
    checks++;
    if (act_a === 12'hFFF) begin errors++; $display("[TB] FAIL midslot_prelit got %h want lit", act_a); end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (act_a !== 12'hFFF) begin errors++; $display("[TB] FAIL midslot_async_a got %h want fff", act_a); end
    if (act_b !== 12'hFFF) begin errors++; $display("[TB] FAIL midslot_async_b got %h want fff", act_b); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) dig[i] = 4'($urandom);
    dp = 4'($urandom);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks += 2;
      if (act_a !== exp_a) begin errors++; $display("[TB] FAIL restart_a k=%0d got %h want %h", k, act_a, exp_a); end
      if (act_b !== exp_b) begin errors++; $display("[TB] FAIL restart_b k=%0d got %h want %h", k, act_b, exp_b); end
    end
  endtask

  initial begin
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    #1;
    test_reset();
    test_basic_scan();
    test_blanking(4'd0, 4'd0, 4'd5, 4'd0, 2 * (DIV - GUARD));
    test_blanking(4'd0, 4'd0, 4'd0, 4'd0, DIV - GUARD);
    test_hex_dp();
    test_frame_coherence();
    test_random();
    test_reset_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
